// File: rtl/axi_rd_burst_split.sv
// ---------------------------------------------------------------------------
// axi_rd_burst_split
//
// Purpose:
//   Sits in front of the on-chip AXI memory wrapper on the read path. That
//   wrapper only understands single-beat reads, so this block accepts a full
//   AXI4 read burst (FIXED / INCR / WRAP, 1..256 beats) and replays it
//   downstream as a serial sequence of single-beat reads. The returned beats
//   are handed back to the master with the original RID and a correct RLAST.
//   Only one downstream read is outstanding at a time.
//
// Optional feature (macro AXI_RD_SPLIT_ERR_EN):
//   Defined   - reserved bursts (2'b11) and WRAP bursts whose length is not
//               2/4/8/16 beats are rejected without touching memory; the
//               block returns len+1 SLVERR beats with zero data itself.
//   Undefined - reserved bursts behave as INCR, WRAP always uses the boundary
//               formula, and no error response is generated internally.
//
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_ar* / o_arready          upstream AXI read-address channel
//   o_r*  / i_rready           upstream AXI read-data channel
//   o_m_ar* / i_m_arready      downstream single-beat read-address channel
//   i_m_r* / o_m_rready        downstream read-data channel
//
// Parameters:
//   ID_WIDTH  width of ARID/RID (>= 1)
//   AW        address width on both sides (>= 16 so the WRAP boundary fits)
//   DW        data width, fixed at 64 by the memory wrapper
// ---------------------------------------------------------------------------
module axi_rd_burst_split #(
    parameter int ID_WIDTH = 1,
    parameter int AW       = 32,
    parameter int DW       = 64
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [ID_WIDTH-1:0] i_arid,
    input  logic [AW-1:0]       i_araddr,
    input  logic [7:0]          i_arlen,
    input  logic [2:0]          i_arsize,
    input  logic [1:0]          i_arburst,
    input  logic                i_arvalid,
    output logic                o_arready,
    output logic [ID_WIDTH-1:0] o_rid,
    output logic [DW-1:0]       o_rdata,
    output logic [1:0]          o_rresp,
    output logic                o_rlast,
    output logic                o_rvalid,
    input  logic                i_rready,
    output logic [AW-1:0]       o_m_araddr,
    output logic [2:0]          o_m_arsize,
    output logic                o_m_arvalid,
    input  logic                i_m_arready,
    input  logic [DW-1:0]       i_m_rdata,
    input  logic [1:0]          i_m_rresp,
    input  logic                i_m_rvalid,
    output logic                o_m_rready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
`ifdef AXI_RD_SPLIT_ERR_EN
    localparam logic [1:0] S_ERR  = 2'd3;
`endif

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    logic [1:0]          state_q,   state_d;
    logic [ID_WIDTH-1:0] id_q,      id_d;
    logic [AW-1:0]       addr_q,    addr_d;
    logic [7:0]          len_q,     len_d;
    logic [2:0]          size_q,    size_d;
    logic [1:0]          burst_q,   burst_d;
    logic [7:0]          cnt_q,     cnt_d;
    logic                arready_q, arready_d;

    logic [AW-1:0] step;
    logic [AW-1:0] addr_inc;
    logic [AW-1:0] wrap_mask;
    logic [AW-1:0] addr_next;
    logic          last_beat;
    logic          burst_illegal;

    // Address of the following beat. WRAP keeps the bits above the wrap
    // boundary and lets only the bits inside it advance. Anything that is
    // not FIXED or WRAP (including the reserved encoding) steps like INCR.
    always_comb begin
        step      = AW'(1) << size_q;
        addr_inc  = addr_q + step;
        wrap_mask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
        case (burst_q)
            BURST_FIXED: addr_next = addr_q;
            BURST_WRAP:  addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
            default:     addr_next = addr_inc;
        endcase
    end

    // Classify the incoming request before it is accepted, so an illegal
    // burst can go straight to the error state without a downstream read.
    always_comb begin
`ifdef AXI_RD_SPLIT_ERR_EN
        burst_illegal = (i_arburst == 2'b11) ||
                        ((i_arburst == BURST_WRAP) &&
                         !((i_arlen == 8'd1) || (i_arlen == 8'd3) ||
                           (i_arlen == 8'd7) || (i_arlen == 8'd15)));
`else
        burst_illegal = 1'b0;
`endif
    end

    assign last_beat = (cnt_q == len_q);

    // Main FSM. The R payload is a straight combinational pass-through in
    // DATA so no beat is ever held in this block. Every output is forced to
    // zero while reset is high, which also cuts off a beat in flight.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        cnt_d       = cnt_q;
        o_m_arvalid = 1'b0;
        o_m_rready  = 1'b0;
        o_rvalid    = 1'b0;
        o_rdata     = '0;
        o_rresp     = 2'b00;
        o_rlast     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_arvalid && arready_q) begin
                    id_d    = i_arid;
                    addr_d  = i_araddr;
                    len_d   = i_arlen;
                    size_d  = i_arsize;
                    burst_d = i_arburst;
                    cnt_d   = 8'd0;
`ifdef AXI_RD_SPLIT_ERR_EN
                    state_d = burst_illegal ? S_ERR : S_ADDR;
`else
                    state_d = S_ADDR;
`endif
                end
            end
            S_ADDR: begin
                o_m_arvalid = 1'b1;
                if (i_m_arready) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                o_rvalid   = i_m_rvalid;
                o_m_rready = i_rready;
                o_rdata    = i_m_rdata;
                o_rresp    = i_m_rresp;
                o_rlast    = last_beat;
                if (i_m_rvalid && i_rready) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        addr_d  = addr_next;
                        state_d = S_ADDR;
                    end
                end
            end
`ifdef AXI_RD_SPLIT_ERR_EN
            S_ERR: begin
                o_rvalid = 1'b1;
                o_rresp  = 2'b10;
                o_rlast  = last_beat;
                if (i_rready) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // o_arready is registered: it is high exactly when the FSM sits in
        // IDLE, so it is computed from the next state.
        arready_d = (state_d == S_IDLE);

        if (i_rst) begin
            o_m_arvalid = 1'b0;
            o_m_rready  = 1'b0;
            o_rvalid    = 1'b0;
            o_rdata     = '0;
            o_rresp     = 2'b00;
            o_rlast     = 1'b0;
        end
    end

    assign o_arready  = arready_q & ~i_rst;
    assign o_rid      = i_rst ? '0 : id_q;
    assign o_m_araddr = i_rst ? '0 : addr_q;
    assign o_m_arsize = i_rst ? 3'd0 : size_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= 8'd0;
            size_q    <= 3'd0;
            burst_q   <= 2'b00;
            cnt_q     <= 8'd0;
            arready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            arready_q <= arready_d;
        end
    end

endmodule
